// File: rtl/ryuki_datatypes.sv
// Shared trace record types produced by the pipeline tracer and queued in trace_buffer.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
    logic [31:0] pc;
  } stage_trace_t;

  typedef struct packed {
    logic [7:0]   tag;
    stage_trace_t if_data;
  } trace_output;

endpackage

// File: rtl/trace_serialiser_pkg.sv
// Constants and FSM encoding for the trace record serialiser.
package trace_serialiser_pkg;

  localparam logic [7:0] TRACE_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2,
    CHECKSUM = 2'd3
  } trace_ser_state_e;

endpackage

// File: rtl/trace_serialiser.sv
// Pops trace_output records and streams them as {header, payload beats LSB first}.
// Define TRACE_SERIALISER_CHECKSUM_EN to append an XOR checksum word to each frame.
module trace_serialiser
  import ryuki_datatypes::*;
  import trace_serialiser_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            data_present,
  input  logic [$bits(trace_output)-1:0]  trace_element_in,
  output logic                            data_request,
  output logic [WORD_W-1:0]               tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            tx_last,
  output logic [15:0]                     frame_count
);

  localparam int TRACE_W = $bits(trace_output);
  localparam int NBEATS  = (TRACE_W + WORD_W - 1) / WORD_W;
  localparam int PAD_W   = NBEATS * WORD_W;
  localparam int BEAT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
`ifdef TRACE_SERIALISER_CHECKSUM_EN
  localparam int  HDR_CNT    = NBEATS + 1;
  localparam bit  LAST_IS_CS = 1'b1;
`else
  localparam int  HDR_CNT    = NBEATS;
  localparam bit  LAST_IS_CS = 1'b0;
`endif

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_HEADER   = HEADER;
  localparam logic [1:0] S_PAYLOAD  = PAYLOAD;
  localparam logic [1:0] S_CHECKSUM = CHECKSUM;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  logic [1:0]                     r_state;
  logic [BEAT_W-1:0]              r_beat;
  logic [NBEATS-1:0][WORD_W-1:0]  r_hold;
  logic [7:0]                     r_seq;

  logic [WORD_W-1:0] w_hdr;
  logic [WORD_W-1:0] w_beat_nxt;
  logic [BEAT_W-1:0] w_beat_idx;
  logic              w_last_nxt;
  logic              w_accept;

  assign w_accept     = tx_valid && tx_ready;
  // Gated by rst so the strobe drops the instant reset asserts.
  assign data_request = !rst && (r_state == S_IDLE) && data_present;

  always_comb begin
    w_hdr        = '0;
    w_hdr[31:0]  = {TRACE_SYNC, r_seq, 16'(HDR_CNT)};
    w_beat_idx   = (r_state == S_PAYLOAD) ? r_beat + 1'b1 : '0;
    w_beat_nxt   = r_hold[w_beat_idx];
    w_last_nxt   = (w_beat_idx == LAST_BEAT) && !LAST_IS_CS;
  end

`ifdef TRACE_SERIALISER_CHECKSUM_EN
  logic [31:0]       r_csum;
  logic [WORD_W-1:0] w_csum_word;

  always_comb begin
    w_csum_word       = '0;
    w_csum_word[31:0] = r_csum ^ tx_data[31:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_hold      <= '0;
      r_seq       <= '0;
      frame_count <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_last     <= 1'b0;
`ifdef TRACE_SERIALISER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_present) begin
            r_hold   <= PAD_W'(trace_element_in);
            tx_data  <= w_hdr;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            r_state  <= S_HEADER;
`ifdef TRACE_SERIALISER_CHECKSUM_EN
            r_csum   <= '0;
`endif
          end
        end
        S_HEADER: begin
          if (w_accept) begin
            r_beat  <= '0;
            tx_data <= w_beat_nxt;
            tx_last <= w_last_nxt;
            r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
`ifdef TRACE_SERIALISER_CHECKSUM_EN
            r_csum <= r_csum ^ tx_data[31:0];
`endif
            if (r_beat == LAST_BEAT) begin
`ifdef TRACE_SERIALISER_CHECKSUM_EN
              tx_data <= w_csum_word;
              tx_last <= 1'b1;
              r_state <= S_CHECKSUM;
`else
              tx_data     <= '0;
              tx_valid    <= 1'b0;
              tx_last     <= 1'b0;
              r_seq       <= r_seq + 1'b1;
              frame_count <= frame_count + 1'b1;
              r_state     <= S_IDLE;
`endif
            end else begin
              r_beat  <= r_beat + 1'b1;
              tx_data <= w_beat_nxt;
              tx_last <= w_last_nxt;
            end
          end
        end
        S_CHECKSUM: begin
          if (w_accept) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            r_seq       <= r_seq + 1'b1;
            frame_count <= frame_count + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_serialiser.sv
// Directed bench for trace_serialiser: table of records with hand-computed beats plus corner sequences.
module tb_trace_serialiser;
  import ryuki_datatypes::*;
  import trace_serialiser_pkg::*;

  localparam int WORD_W = 32;
  localparam int TW     = $bits(trace_output);
  localparam int NB     = (TW + WORD_W - 1) / WORD_W;
`ifdef TRACE_SERIALISER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NW = 1 + NB + CS;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_present;
  logic [TW-1:0]     trace_element_in;
  logic              data_request;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic [15:0]       frame_count;

  always #5 clk = ~clk;

  trace_serialiser #(.WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst),
    .data_present(data_present), .trace_element_in(trace_element_in),
    .data_request(data_request),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .frame_count(frame_count)
  );

  typedef struct {
    logic [7:0]        tag;
    logic [31:0]       ts;
    logic [31:0]       te;
    logic [31:0]       pc;
    logic [3:0][31:0]  beat;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
    int          cyc;
  } cap_t;

  vec_t tbl [5];
  cap_t capq [$];
  int   reqq [$];
  int   n_vec = 0, n_miss = 0, cyc = 0;
  logic p_hold = 1'b0, prev_req = 1'b0, p_last = 1'b0;
  logic [31:0] p_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic trace_output mk(input vec_t v);
    trace_output r;
    r.tag                = v.tag;
    r.if_data.time_start = v.ts;
    r.if_data.time_end   = v.te;
    r.if_data.pc         = v.pc;
    return r;
  endfunction

  // Bus monitor: stall stability, pop strobe spacing, accepted-word capture.
  always @(negedge clk) begin
    cap_t c;
    cyc++;
    if (rst) begin
      p_hold   = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (p_hold) chk("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, p_last, p_data});
      if (data_request) begin
        chk("req_b2b", prev_req, 0);
        reqq.push_back(cyc);
      end
      prev_req = data_request;
      if (tx_valid && tx_ready) begin
        c.d = tx_data; c.last = tx_last; c.cyc = cyc;
        capq.push_back(c);
      end
      p_hold = tx_valid && !tx_ready;
      p_data = tx_data;
      p_last = tx_last;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = data_request;
    end
    chk({nm, "_req"}, got, 1);
    tick();
  endtask

  task automatic wait_end(input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = tx_valid && tx_ready && tx_last;
    end
    chk({nm, "_end"}, got, 1);
    tick();
  endtask

  task automatic check_frame(input vec_t v, input logic [7:0] seq, input string nm,
                             output int hc, output int lc);
    cap_t w;
    logic [31:0] cs = '0;
    hc = 0; lc = 0;
    if (capq.size() < NW) begin
      chk({nm, "_len"}, capq.size(), NW);
      return;
    end
    w = capq.pop_front();
    hc = w.cyc;
    chk({nm, "_hdr"}, w.d, {8'hA5, seq, 16'(NB + CS)});
    chk({nm, "_hdr_last"}, w.last, 0);
    for (int k = 0; k < NB; k++) begin
      w = capq.pop_front();
      cs ^= v.beat[k];
      chk($sformatf("%s_beat%0d", nm, k), w.d, v.beat[k]);
      chk($sformatf("%s_last%0d", nm, k), w.last, (k == NB - 1) && (CS == 0));
      lc = w.cyc;
    end
`ifdef TRACE_SERIALISER_CHECKSUM_EN
    w = capq.pop_front();
    chk({nm, "_csum"}, w.d, cs);
    chk({nm, "_csum_last"}, w.last, 1);
    lc = w.cyc;
`endif
  endtask

  task automatic run_one(input vec_t v, input logic [7:0] seq, input int stall, input string nm);
    int hc, lc;
    capq.delete(); reqq.delete();
    data_present = 1'b1;
    trace_element_in = mk(v);
    wait_req(nm);
    data_present = 1'b0;
    if (stall > 0) begin
      tick();
      tx_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1 tx_ready = 1'b1;
    end
    wait_end(nm);
    check_frame(v, seq, nm, hc, lc);
    chk({nm, "_nreq"}, reqq.size(), 1);
    if (reqq.size() > 0) chk({nm, "_lat"}, hc - reqq[0], 1);
    chk({nm, "_span"}, lc - hc, NW - 1 + stall);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
  endtask

  initial begin
    int hc [4];
    int lc [4];
    int h, l;
    // Beats are record bits LSB word first: pc, time_end, time_start, {24'0, tag}.
    tbl[0] = '{8'h11, 32'd100,        32'd120,        32'h8000_0000,
               {32'h0000_0011, 32'h0000_0064, 32'h0000_0078, 32'h8000_0000}};
    tbl[1] = '{8'h22, 32'd200,        32'hDEAD_BEEF,  32'h8000_0004,
               {32'h0000_0022, 32'h0000_00C8, 32'hDEAD_BEEF, 32'h8000_0004}};
    tbl[2] = '{8'h33, 32'd300,        32'h0000_0000,  32'hFFFF_FFFF,
               {32'h0000_0033, 32'h0000_012C, 32'h0000_0000, 32'hFFFF_FFFF}};
    tbl[3] = '{8'hFF, 32'd400,        32'h1234_5678,  32'h0000_0010,
               {32'h0000_00FF, 32'h0000_0190, 32'h1234_5678, 32'h0000_0010}};
    tbl[4] = '{8'hA5, 32'hCAFE_F00D,  32'h0BAD_F00D,  32'h0000_1000,
               {32'h0000_00A5, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'h0000_1000}};

    rst = 1'b1; data_present = 1'b1; tx_ready = 1'b1; trace_element_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   data_request, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_last",  tx_last, 0);
    chk("rst_data",  tx_data, 0);
    chk("rst_fc",    frame_count, 0);
    @(posedge clk); #1;
    rst = 1'b0; data_present = 1'b0;
    tick();

    run_one(tbl[0], 8'd0, 0, "single");
    chk("single_fc", frame_count, 1);

    run_one(tbl[4], 8'd1, 3, "stall");
    chk("stall_fc", frame_count, 2);

    // Reset while payload beat 1 is on the bus.
    capq.delete();
    data_present = 1'b1;
    trace_element_in = mk(tbl[1]);
    wait_req("rstmid");
    tick(); tick();
    chk("rstmid_pre", {tx_valid, tx_data}, {1'b1, tbl[1].beat[1]});
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", tx_valid, 0);
    chk("rstmid_req",   data_request, 0);
    chk("rstmid_last",  tx_last, 0);
    chk("rstmid_fc",    frame_count, 0);
    data_present = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("after_rst_fc0", frame_count, 0);
    run_one(tbl[2], 8'd0, 0, "after_rst");
    chk("after_rst_fc1", frame_count, 1);

    // Back-to-back: data_present held high, record swapped after each pop.
    pulse_reset();
    capq.delete(); reqq.delete();
    data_present = 1'b1;
    trace_element_in = mk(tbl[0]);
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("b2b%0d", i));
      if (i < 3) trace_element_in = mk(tbl[i + 1]);
      else       data_present = 1'b0;
    end
    wait_end("b2b");
    for (int i = 0; i < 4; i++)
      check_frame(tbl[i], 8'(i), $sformatf("b2b%0d", i), hc[i], lc[i]);
    chk("b2b_nreq", reqq.size(), 4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("b2b_gap%0d", i), hc[i] - lc[i - 1], 2);
      if (reqq.size() > i) chk($sformatf("b2b_reqcyc%0d", i), reqq[i] - lc[i - 1], 1);
    end
    chk("b2b_fc", frame_count, 4);

    // Sequence number wrap over 257 frames.
    pulse_reset();
    capq.delete(); reqq.delete();
    data_present = 1'b1;
    trace_element_in = mk(tbl[0]);
    for (int i = 0; i < 257; i++) begin
      wait_req("wrap");
      if (i < 256) trace_element_in = mk(tbl[(i + 1) % 4]);
      else         data_present = 1'b0;
    end
    wait_end("wrap");
    for (int i = 0; i < 257; i++)
      check_frame(tbl[i % 4], 8'(i), $sformatf("wrap%0d", i), h, l);
    chk("wrap_fc", frame_count, 257);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
